// File: rtl/branch_sequencer.sv
// Conditional-flow sequencer for Bcc/BRA, DBcc and Scc: drives the condition-unit
// select, fetches word displacements, performs the DBcc decrement and reports next PC.
module branch_sequencer (
  input  logic        CLK_I,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [3:0]  cond_sel,
  input  logic [7:0]  disp8,
  input  logic [31:0] pc,
  input  logic [15:0] dn_in,
  input  logic        condition_in,
  output logic [3:0]  cond_out,
  output logic        ext_req,
  input  logic        ext_ack,
  input  logic [15:0] ext_data,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic [15:0] dn_out,
  output logic        dn_we,
  output logic [7:0]  scc_byte,
  output logic        scc_we
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EVAL  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DEC   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_BCC  = 2'b00;
  localparam logic [1:0] OP_DBCC = 2'b01;
  localparam logic [1:0] OP_SCC  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  disp8_q, disp8_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] dn_q, dn_d;
  logic        cond_q, cond_d;
  logic [15:0] disp16_q, disp16_d;
  logic        taken_q, taken_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic [15:0] dn_out_q, dn_out_d;
  logic [7:0]  scc_byte_q, scc_byte_d;

  logic [31:0] pc_plus2;
  logic [31:0] disp8_sext;
  logic [31:0] ext_sext;
  logic [31:0] disp16_sext;

  assign pc_plus2    = pc_q + 32'd2;
  assign disp8_sext  = {{24{disp8_q[7]}}, disp8_q};
  assign ext_sext    = {{16{ext_data[15]}}, ext_data};
  assign disp16_sext = {{16{disp16_q[15]}}, disp16_q};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    disp8_d    = disp8_q;
    pc_d       = pc_q;
    dn_d       = dn_q;
    cond_d     = cond_q;
    disp16_d   = disp16_q;
    taken_d    = taken_q;
    next_pc_d  = next_pc_q;
    dn_out_d   = dn_out_q;
    scc_byte_d = scc_byte_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EVAL;
          // Reserved op behaves as a Bcc whose test is forced to "false".
          op_d    = (op == OP_RSVD) ? OP_BCC : op;
          sel_d   = (op == OP_RSVD) ? 4'b0001 : cond_sel;
          disp8_d = disp8;
          pc_d    = pc;
          dn_d    = dn_in;
        end
      end
      S_EVAL: begin
        cond_d = condition_in;
        if (op_q == OP_SCC) begin
          state_d    = S_DONE;
          scc_byte_d = condition_in ? 8'hFF : 8'h00;
          taken_d    = 1'b0;
          next_pc_d  = pc_q;
        end else if (op_q == OP_BCC && disp8_q != 8'h00) begin
          state_d   = S_DONE;
          taken_d   = condition_in;
          next_pc_d = condition_in ? (pc_q + disp8_sext) : pc_q;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (ext_ack) begin
          disp16_d = ext_data;
          if (op_q == OP_DBCC && !cond_q) begin
            state_d  = S_DEC;
            dn_out_d = dn_q - 16'd1;
          end else if (op_q == OP_DBCC) begin
            state_d   = S_DONE;
            taken_d   = 1'b0;
            next_pc_d = pc_plus2;
          end else begin
            state_d   = S_DONE;
            taken_d   = cond_q;
            next_pc_d = cond_q ? (pc_q + ext_sext) : pc_plus2;
          end
        end
      end
      S_DEC: begin
        state_d = S_DONE;
        // Counter wrapped to -1: loop terminates and falls through.
        if (dn_out_q == 16'hFFFF) begin
          taken_d   = 1'b0;
          next_pc_d = pc_plus2;
        end else begin
          taken_d   = 1'b1;
          next_pc_d = pc_q + disp16_sext;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_BCC;
      sel_q      <= 4'b0000;
      disp8_q    <= 8'h00;
      pc_q       <= 32'h0;
      dn_q       <= 16'h0;
      cond_q     <= 1'b0;
      disp16_q   <= 16'h0;
      taken_q    <= 1'b0;
      next_pc_q  <= 32'h0;
      dn_out_q   <= 16'h0;
      scc_byte_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      disp8_q    <= disp8_d;
      pc_q       <= pc_d;
      dn_q       <= dn_d;
      cond_q     <= cond_d;
      disp16_q   <= disp16_d;
      taken_q    <= taken_d;
      next_pc_q  <= next_pc_d;
      dn_out_q   <= dn_out_d;
      scc_byte_q <= scc_byte_d;
    end
  end

  assign cond_out = sel_q;
  assign ext_req  = (state_q == S_FETCH);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign dn_we    = (state_q == S_DEC);
  assign scc_we   = (state_q == S_DONE) && (op_q == OP_SCC);
  assign taken    = taken_q;
  assign next_pc  = next_pc_q;
  assign dn_out   = dn_out_q;
  assign scc_byte = scc_byte_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: a small condition-unit model feeds condition_in, and
// expected results are queued per operation and popped when the strobes appear.
module tb_branch_sequencer;

  logic        CLK_I = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [3:0]  cond_sel = 4'h0;
  logic [7:0]  disp8 = 8'h00;
  logic [31:0] pc = 32'h0;
  logic [15:0] dn_in = 16'h0;
  logic        condition_in;
  logic [3:0]  cond_out;
  logic        ext_req;
  logic        ext_ack = 1'b0;
  logic [15:0] ext_data = 16'h0;
  logic        busy, done, taken, dn_we, scc_we;
  logic [31:0] next_pc;
  logic [15:0] dn_out;
  logic [7:0]  scc_byte;

  logic [3:0]  ccr = 4'h0;  // {N, Z, V, C}

  logic [32:0] exp_q[$];      // {taken, next_pc}
  logic [15:0] exp_dn_q[$];
  logic [7:0]  exp_scc_q[$];

  int total = 0;
  int bad = 0;

  always #5 CLK_I = ~CLK_I;

  branch_sequencer dut (
    .CLK_I(CLK_I), .reset_n(reset_n), .start(start), .op(op), .cond_sel(cond_sel),
    .disp8(disp8), .pc(pc), .dn_in(dn_in), .condition_in(condition_in),
    .cond_out(cond_out), .ext_req(ext_req), .ext_ack(ext_ack), .ext_data(ext_data),
    .busy(busy), .done(done), .taken(taken), .next_pc(next_pc), .dn_out(dn_out),
    .dn_we(dn_we), .scc_byte(scc_byte), .scc_we(scc_we)
  );

  function automatic logic cc_eval(input logic [3:0] sel, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (sel)
      4'h0: cc_eval = 1'b1;
      4'h1: cc_eval = 1'b0;
      4'h2: cc_eval = !c && !z;
      4'h3: cc_eval = c || z;
      4'h4: cc_eval = !c;
      4'h5: cc_eval = c;
      4'h6: cc_eval = !z;
      4'h7: cc_eval = z;
      4'h8: cc_eval = !v;
      4'h9: cc_eval = v;
      4'hA: cc_eval = !n;
      4'hB: cc_eval = n;
      4'hC: cc_eval = (n == v);
      4'hD: cc_eval = (n != v);
      4'hE: cc_eval = (n == v) && !z;
      default: cc_eval = z || (n != v);
    endcase
  endfunction

  assign condition_in = cc_eval(cond_out, ccr);

  task automatic tick;
    @(posedge CLK_I);
    #1;
  endtask

  // One operation: model the result, drive start, answer ext_req after k wait
  // cycles, check strobes and done latency, then check the return to IDLE.
  task automatic run_op(input string name, input logic [1:0] o, input logic [3:0] sel,
                        input logic [7:0] d8, input logic [31:0] p, input logic [15:0] dn,
                        input logic [3:0] flags, input int k, input logic [15:0] xd,
                        input logic hold_start, input logic flip_ccr);
    logic [3:0]  esel;
    logic        c;
    logic        t;
    logic [31:0] np;
    logic [15:0] dec;
    logic [32:0] e;
    int          lat;
    int          req_cnt;
    int          cyc;
    logic        got;
    esel = (o == 2'b11) ? 4'b0001 : sel;
    c    = cc_eval(esel, flags);
    if (o == 2'b10) begin
      t = 1'b0; np = p; lat = 2;
      exp_scc_q.push_back(c ? 8'hFF : 8'h00);
    end else if (o == 2'b01) begin
      if (c) begin
        t = 1'b0; np = p + 32'd2; lat = 3 + k;
      end else begin
        dec = dn - 16'd1;
        exp_dn_q.push_back(dec);
        lat = 4 + k;
        if (dec == 16'hFFFF) begin
          t = 1'b0; np = p + 32'd2;
        end else begin
          t = 1'b1; np = p + {{16{xd[15]}}, xd};
        end
      end
    end else if (d8 != 8'h00) begin
      t = c; np = c ? p + {{24{d8[7]}}, d8} : p; lat = 2;
    end else begin
      t = c; np = c ? p + {{16{xd[15]}}, xd} : p + 32'd2; lat = 3 + k;
    end
    exp_q.push_back({t, np});

    ccr = flags; op = o; cond_sel = sel; disp8 = d8; pc = p; dn_in = dn;
    start = 1'b1;
    req_cnt = 0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 40) begin
      tick;
      cyc++;
      if (!hold_start || cyc >= 2) start = 1'b0;
      if (cyc == 1) begin
        total++;
        if (cond_out !== esel || busy !== 1'b1) begin
          bad++;
          $display("FAIL %s eval: cond_out=%h busy=%b required cond_out=%h busy=1", name, cond_out, busy, esel);
        end
      end
      if (flip_ccr && cyc == 2) ccr = ~flags;
      ext_ack = 1'b0;
      if (ext_req === 1'b1) begin
        if (req_cnt == k) begin
          ext_ack = 1'b1;
          ext_data = xd;
        end
        req_cnt++;
      end
      if (dn_we === 1'b1) begin
        total++;
        if (exp_dn_q.size() == 0) begin
          bad++;
          $display("FAIL %s dn_we: unexpected write dn_out=%h, required no write", name, dn_out);
        end else begin
          dec = exp_dn_q.pop_front();
          if (dn_out !== dec || cyc != lat - 1) begin
            bad++;
            $display("FAIL %s dn_write: dn_out=%h cycle=%0d required %h cycle=%0d", name, dn_out, cyc, dec, lat - 1);
          end
        end
      end
      if (scc_we === 1'b1) begin
        total++;
        if (exp_scc_q.size() == 0) begin
          bad++;
          $display("FAIL %s scc_we: unexpected write scc_byte=%h", name, scc_byte);
        end else if (scc_byte !== exp_scc_q[0] || done !== 1'b1) begin
          bad++;
          $display("FAIL %s scc_write: scc_byte=%h done=%b required %h done=1", name, scc_byte, done, exp_scc_q[0]);
          void'(exp_scc_q.pop_front());
        end else begin
          void'(exp_scc_q.pop_front());
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        total++;
        if ({taken, next_pc} !== e || cyc != lat) begin
          bad++;
          $display("FAIL %s result: taken=%b next_pc=%h cycle=%0d required taken=%b next_pc=%h cycle=%0d",
                   name, taken, next_pc, cyc, e[32], e[31:0], lat);
        end
      end
    end
    start = 1'b0;
    ext_ack = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
      void'(exp_q.pop_front());
    end
    total++;
    if (exp_dn_q.size() != 0 || exp_scc_q.size() != 0) begin
      bad++;
      $display("FAIL %s strobes: pending dn=%0d scc=%0d required 0 0", name, exp_dn_q.size(), exp_scc_q.size());
      exp_dn_q.delete();
      exp_scc_q.delete();
    end
    tick;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || taken !== t || next_pc !== np) begin
      bad++;
      $display("FAIL %s idle_hold: busy=%b done=%b taken=%b next_pc=%h required 0 0 %b %h",
               name, busy, done, taken, next_pc, t, np);
    end
    if (hold_start) begin
      for (int i = 0; i < 3; i++) begin
        tick;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          bad++;
          $display("FAIL %s ignored_start: done=%b busy=%b required 0 0", name, done, busy);
        end
      end
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    tick;
    tick;
    total++;
    if ({busy, done, taken, ext_req, dn_we, scc_we} !== 6'b0 || next_pc !== 32'h0 ||
        dn_out !== 16'h0 || scc_byte !== 8'h0 || cond_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_values: busy=%b done=%b taken=%b ext_req=%b dn_we=%b scc_we=%b next_pc=%h dn_out=%h scc_byte=%h cond_out=%h required all 0",
               busy, done, taken, ext_req, dn_we, scc_we, next_pc, dn_out, scc_byte, cond_out);
    end
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_bcc_byte;
    run_op("bcc_b_eq_taken", 2'b00, 4'b0111, 8'hFE, 32'h0000_1000, 16'h0, 4'b0100, 0, 16'h0, 1'b0, 1'b0);
    run_op("bcc_b_eq_not", 2'b00, 4'b0111, 8'hFE, 32'h0000_1000, 16'h0, 4'b0000, 0, 16'h0, 1'b0, 1'b0);
    run_op("bra_b_fwd", 2'b00, 4'b0000, 8'h7F, 32'hFFFF_FFF0, 16'h0, 4'b0000, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_bcc_word;
    run_op("bcc_w_wait3", 2'b00, 4'b0111, 8'h00, 32'h0001_0000, 16'h0, 4'b0100, 3, 16'h8000, 1'b0, 1'b1);
    run_op("bcc_w_k0_not", 2'b00, 4'b0110, 8'h00, 32'h0000_3000, 16'h0, 4'b0100, 0, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_dbcc;
    run_op("dbcc_loop", 2'b01, 4'b0001, 8'h00, 32'h0000_2000, 16'h0002, 4'b0000, 0, 16'hFFFC, 1'b0, 1'b0);
    run_op("dbcc_expire", 2'b01, 4'b0001, 8'h00, 32'h0000_2000, 16'h0000, 4'b0000, 2, 16'hFFFC, 1'b0, 1'b0);
    run_op("dbcc_cond_true", 2'b01, 4'b0000, 8'h00, 32'h0000_2000, 16'h0005, 4'b0000, 1, 16'hFFFC, 1'b0, 1'b1);
  endtask

  task automatic test_scc;
    run_op("scc_lt_true", 2'b10, 4'b1101, 8'h00, 32'h0000_4000, 16'h0, 4'b1000, 0, 16'h0, 1'b1, 1'b0);
    run_op("scc_lt_false", 2'b10, 4'b1101, 8'h00, 32'h0000_4000, 16'h0, 4'b1010, 0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reserved;
    run_op("reserved_b", 2'b11, 4'b0000, 8'h10, 32'h0000_5000, 16'h0, 4'b0000, 0, 16'h0, 1'b0, 1'b0);
    run_op("reserved_w", 2'b11, 4'b0000, 8'h00, 32'h0000_5000, 16'h0, 4'b0000, 1, 16'h0040, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d8;
    for (int i = 0; i < 12; i++) begin
      d8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      run_op("random", 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), d8,
             $urandom(), 16'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), 16'($urandom()), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_fetch;
    ccr = 4'b0000; op = 2'b00; cond_sel = 4'b0000; disp8 = 8'h00; pc = 32'h0000_6000;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    total++;
    if (ext_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_fetch_req: ext_req=%b required 1", ext_req);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (ext_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_fetch_abort: ext_req=%b busy=%b done=%b required 0 0 0", ext_req, busy, done);
    end
    tick;
    reset_n = 1'b1;
    tick;
    ext_ack = 1'b1;
    ext_data = 16'h1234;
    tick;
    ext_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || ext_req !== 1'b0) begin
        bad++;
        $display("FAIL late_ack: done=%b busy=%b ext_req=%b required 0 0 0", done, busy, ext_req);
      end
    end
  endtask

  initial begin
    test_reset;
    test_bcc_byte;
    test_bcc_word;
    test_dbcc;
    test_scc;
    test_reserved;
    test_back_to_back;
    test_reset_mid_fetch;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
